integ_scheduler: RTL

//  Time-shared controller and datapath for the cascaded-integrator audio stage, running on the 50 MHz system clock.

---
 rtl/integ_scheduler_pkg.sv | 18 +
 rtl/integ_scheduler_if.sv | 27 ++
 rtl/integ_state_rf.sv | 33 +++
 rtl/integ_scheduler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/integ_scheduler_pkg.sv
// Shared types and helpers for the time-shared cascaded-integrator scheduler.
package integ_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_e;

   localparam logic CH_L = 1'b0;
   localparam logic CH_R = 1'b1;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/integ_scheduler_if.sv
// I2S-side sample, configuration and status bundle of the integrator scheduler.
interface integ_scheduler_if #(
   parameter int DATA_W = 16
);
   logic              LRCK;
   logic [DATA_W-1:0] AUD_L_IN;
   logic [DATA_W-1:0] AUD_R_IN;
   logic              CFG_EN;
   logic              CFG_BYPASS;
   logic              CFG_CLR;
   logic [DATA_W-1:0] AUD_L_OUT;
   logic [DATA_W-1:0] AUD_R_OUT;
   logic              OUT_VALID;
   logic              OUT_CH;
   logic              BUSY;
   logic              OVERRUN;

   modport slave (
      input  LRCK, AUD_L_IN, AUD_R_IN, CFG_EN, CFG_BYPASS, CFG_CLR,
      output AUD_L_OUT, AUD_R_OUT, OUT_VALID, OUT_CH, BUSY, OVERRUN
   );

   modport master (
      output LRCK, AUD_L_IN, AUD_R_IN, CFG_EN, CFG_BYPASS, CFG_CLR,
      input  AUD_L_OUT, AUD_R_OUT, OUT_VALID, OUT_CH, BUSY, OVERRUN
   );
endinterface

// File: rtl/integ_state_rf.sv
// Per-channel integrator state: 2 x STAGES words, async read, one sync write, clear-all.
module integ_state_rf
   import integ_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int STAGES = 11
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clr_i,
   input  logic                       we_i,
   input  logic                       wch_i,
   input  logic [idx_w(STAGES)-1:0]   widx_i,
   input  logic [DATA_W-1:0]          wdata_i,
   input  logic                       rch_i,
   input  logic [idx_w(STAGES)-1:0]   ridx_i,
   output logic [DATA_W-1:0]          rdata_o
);
   logic [DATA_W-1:0] mem_q [2][STAGES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '{default: '0};
      end else if (clr_i) begin
         mem_q <= '{default: '0};
      end else if (we_i) begin
         mem_q[wch_i][widx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rch_i][ridx_i];

endmodule

// File: rtl/integ_scheduler.sv
// Time-shared cascaded integrator: LRCK edges post L/R jobs, one adder walks all stages per sample.
module integ_scheduler
   import integ_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int STAGES = 11
) (
   input logic             CLOCK_50,
   input logic             RST_N,
   integ_scheduler_if.slave aud
);
   localparam int KW = idx_w(STAGES);
   localparam logic [KW-1:0] LAST = KW'(STAGES - 1);

   state_e              state_q, state_d;
   logic                lrck_s1_q, lrck_s2_q, lrck_s3_q;
   logic [KW-1:0]       k_q, k_d;
   logic [DATA_W-1:0]   p_q, p_d, out_tmp_q, out_tmp_d;
   logic                job_ch_q, job_ch_d;
   logic [DATA_W-1:0]   job_smp_q, job_smp_d;
   logic                pend_full_q, pend_full_d, pend_ch_q, pend_ch_d;
   logic [DATA_W-1:0]   pend_smp_q, pend_smp_d;
   logic [DATA_W-1:0]   out_l_q, out_l_d, out_r_q, out_r_d;
   logic                out_valid_q, out_valid_d, out_ch_q, out_ch_d;
   logic                overrun_q, overrun_d;
   logic                rise, fall, edge_v, edge_ch;
   logic [DATA_W-1:0]   edge_smp, rf_rdata, sum;
   logic [KW-1:0]       rf_ridx;
   logic                rf_we;

   assign rise     = lrck_s2_q & ~lrck_s3_q;
   assign fall     = ~lrck_s2_q & lrck_s3_q;
   assign edge_v   = aud.CFG_EN & (rise | fall);
   assign edge_ch  = fall ? CH_R : CH_L;
   assign edge_smp = fall ? aud.AUD_R_IN : aud.AUD_L_IN;
   assign rf_ridx  = (state_q == S_LOAD) ? LAST : k_q;
   assign sum      = p_q + rf_rdata;

   integ_state_rf #(.DATA_W(DATA_W), .STAGES(STAGES)) u_rf (
      .clk_i  (CLOCK_50),
      .rst_ni (RST_N),
      .clr_i  (aud.CFG_CLR),
      .we_i   (rf_we),
      .wch_i  (job_ch_q),
      .widx_i (k_q),
      .wdata_i(sum),
      .rch_i  (job_ch_q),
      .ridx_i (rf_ridx),
      .rdata_o(rf_rdata)
   );

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      p_d         = p_q;
      out_tmp_d   = out_tmp_q;
      job_ch_d    = job_ch_q;
      job_smp_d   = job_smp_q;
      pend_full_d = pend_full_q;
      pend_ch_d   = pend_ch_q;
      pend_smp_d  = pend_smp_q;
      out_l_d     = out_l_q;
      out_r_d     = out_r_q;
      out_ch_d    = out_ch_q;
      out_valid_d = 1'b0;
      overrun_d   = overrun_q;
      rf_we       = 1'b0;
      if (aud.CFG_CLR) begin
         state_d     = S_IDLE;
         pend_full_d = 1'b0;
         overrun_d   = 1'b0;
      end else begin
         // Pending job outranks a same-cycle edge, which then takes the slot.
         if (state_q == S_IDLE) begin
            if (pend_full_q) begin
               job_ch_d    = pend_ch_q;
               job_smp_d   = pend_smp_q;
               pend_full_d = edge_v;
               pend_ch_d   = edge_ch;
               pend_smp_d  = edge_smp;
               state_d     = S_LOAD;
            end else if (edge_v) begin
               job_ch_d  = edge_ch;
               job_smp_d = edge_smp;
               state_d   = S_LOAD;
            end
         end else if (edge_v) begin
            if (pend_full_q) begin
               overrun_d = 1'b1;
            end else begin
               pend_full_d = 1'b1;
               pend_ch_d   = edge_ch;
               pend_smp_d  = edge_smp;
            end
         end
         // Outputs are loaded on entry to DONE so data and OUT_VALID appear together.
         case (state_q)
            S_LOAD: begin
               if (aud.CFG_BYPASS) begin
                  if (job_ch_q == CH_L) out_l_d = job_smp_q;
                  else                  out_r_d = job_smp_q;
                  out_ch_d    = job_ch_q;
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  p_d       = job_smp_q;
                  out_tmp_d = rf_rdata;
                  k_d       = '0;
                  state_d   = S_RUN;
               end
            end
            S_RUN: begin
               rf_we = 1'b1;
               p_d   = sum;
               if (k_q == LAST) begin
                  if (job_ch_q == CH_L) out_l_d = out_tmp_q;
                  else                  out_r_d = out_tmp_q;
                  out_ch_d    = job_ch_q;
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         lrck_s1_q   <= 1'b0;
         lrck_s2_q   <= 1'b0;
         lrck_s3_q   <= 1'b0;
         k_q         <= '0;
         p_q         <= '0;
         out_tmp_q   <= '0;
         job_ch_q    <= CH_L;
         job_smp_q   <= '0;
         pend_full_q <= 1'b0;
         pend_ch_q   <= CH_L;
         pend_smp_q  <= '0;
         out_l_q     <= '0;
         out_r_q     <= '0;
         out_ch_q    <= CH_L;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         lrck_s1_q   <= aud.LRCK;
         lrck_s2_q   <= lrck_s1_q;
         lrck_s3_q   <= lrck_s2_q;
         k_q         <= k_d;
         p_q         <= p_d;
         out_tmp_q   <= out_tmp_d;
         job_ch_q    <= job_ch_d;
         job_smp_q   <= job_smp_d;
         pend_full_q <= pend_full_d;
         pend_ch_q   <= pend_ch_d;
         pend_smp_q  <= pend_smp_d;
         out_l_q     <= out_l_d;
         out_r_q     <= out_r_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign aud.AUD_L_OUT = out_l_q;
   assign aud.AUD_R_OUT = out_r_q;
   assign aud.OUT_VALID = out_valid_q;
   assign aud.OUT_CH    = out_ch_q;
   assign aud.BUSY      = (state_q != S_IDLE);
   assign aud.OVERRUN   = overrun_q;

endmodule
